pcie_axi_target_ram: RTL and testbench

PCIE_AXI_TARGET_RAM -- requirements
Module: pcie_axi_target_ram

---
 rtl/pcie_tgt_pkg.sv | 37 +++
 rtl/pcie_tgt_ram.sv | 34 +++
 rtl/pcie_axi_target_ram.sv | 241 ++++++++++++++++++++++++
 tb/tb_pcie_axi_target_ram.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tgt_pkg.sv
// Shared widths, response codes and FSM encodings for the AXI target RAM.
package pcie_tgt_pkg;

    localparam int DATA_W = 256;
    localparam int STRB_W = DATA_W / 8;
    localparam int ID_W   = 8;
    localparam int LEN_W  = 8;
    localparam int ADDR_W = 64;

    // Only full-width 32-byte beats are accepted.
    localparam logic [2:0] SIZE_32B = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // One odd-parity bit per data byte: bit i is set when byte i has an even number of ones.
    function automatic logic [STRB_W-1:0] odd_parity(input logic [DATA_W-1:0] d);
        logic [STRB_W-1:0] p;
        p = '0;
        for (int i = 0; i < STRB_W; i++) begin
            p[i] = ~^d[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/pcie_tgt_ram.sv
// Byte-enabled word array: one synchronous write port, one asynchronous read port.
// A read of the index being written in the same cycle returns the old contents.
module pcie_tgt_ram
    import pcie_tgt_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [STRB_W-1:0]     i_wstrb,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // Byte-lane write; contents are deliberately not reset so data survives a bus reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pcie_axi_target_ram.sv
// AXI4 slave backed by a small RAM, sitting behind a PCIe BAR window.
// Handshake rule on every channel: a transfer happens on the rising edge where
// both valid and ready are 1; a source holds valid and its payload until then.
// Write and read engines are independent and share only the RAM.
module pcie_axi_target_ram
    import pcie_tgt_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIN_BITS   = 20
) (
    input  logic              axiclk,
    input  logic              axi_rst,
    // write address
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [LEN_W-1:0]  s_awlen,
    input  logic [2:0]        s_awsize,
    input  logic              s_awvalid,
    output logic              s_awready,
    // write data
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [STRB_W-1:0] s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    // write response
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    // read address
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [LEN_W-1:0]  s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic              s_arvalid,
    output logic              s_arready,
    // read data
    output logic [DATA_W-1:0] s_rdata,
    output logic [STRB_W-1:0] s_rdata_par,
    output logic [ID_W-1:0]   s_rid,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready
);

    localparam int IDX_LO = 5;
    localparam int IDX_HI = IDX_LO + DEPTH_LOG2 - 1;

    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;
    localparam logic [LEN_W-1:0]      LEN_ONE = 1;

    // ---------------- write channel ----------------
    wr_state_t               r_wstate;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [ID_W-1:0]         r_bid;
    logic [1:0]              r_bresp;
    logic [DEPTH_LOG2-1:0]   r_widx;
    logic [LEN_W-1:0]        r_wlen;
    logic [LEN_W-1:0]        r_wcnt;
    logic                    r_werr;

    logic                    w_aw_err;
    logic                    w_ram_we;

    // ---------------- read channel ----------------
    rd_state_t               r_rstate;
    logic                    r_arready;
    logic                    r_rvalid;
    logic                    r_rlast;
    logic [DATA_W-1:0]       r_rdata;
    logic [ID_W-1:0]         r_rid;
    logic [1:0]              r_rresp;
    logic [DEPTH_LOG2-1:0]   r_ridx;
    logic [LEN_W-1:0]        r_rlen;
    logic [LEN_W-1:0]        r_rcnt;
    logic                    r_rerr;

    logic                    w_ar_err;
    logic [DEPTH_LOG2-1:0]   w_ar_idx;
    logic [DEPTH_LOG2-1:0]   w_ram_raddr;
    logic [DATA_W-1:0]       w_ram_rdata;

    // Address bits outside the word index and BAR window carry no meaning here.
    logic                    w_unused_addr;
    assign w_unused_addr = ^{s_awaddr[ADDR_W-1:WIN_BITS], s_awaddr[IDX_LO-1:0],
                             s_araddr[ADDR_W-1:WIN_BITS], s_araddr[IDX_LO-1:0]};

    // A burst is rejected if it is not full-width or falls past the RAM inside the window.
    assign w_aw_err = (s_awsize != SIZE_32B) || (s_awaddr[WIN_BITS-1:IDX_HI+1] != '0);
    assign w_ar_err = (s_arsize != SIZE_32B) || (s_araddr[WIN_BITS-1:IDX_HI+1] != '0);
    assign w_ar_idx = s_araddr[IDX_HI:IDX_LO];

    // Rejected bursts still consume their beats but never touch the array.
    assign w_ram_we = s_wvalid && r_wready && !r_werr;

    // While idle the read port looks at the incoming AR so the first beat is ready
    // one cycle after the address handshake; afterwards it follows the burst.
    assign w_ram_raddr = r_arready ? w_ar_idx : r_ridx;

    pcie_tgt_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (axiclk),
        .i_we    (w_ram_we),
        .i_waddr (r_widx),
        .i_wdata (s_wdata),
        .i_wstrb (s_wstrb),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // Write FSM: accept AW, count W beats up to len (no WLAST), then hold B until taken.
    always_ff @(posedge axiclk or posedge axi_rst) begin
        if (axi_rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= RESP_OKAY;
            r_widx    <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (s_awvalid) begin
                        r_bid     <= s_awid;
                        r_bresp   <= w_aw_err ? RESP_SLVERR : RESP_OKAY;
                        r_widx    <= s_awaddr[IDX_HI:IDX_LO];
                        r_wlen    <= s_awlen;
                        r_wcnt    <= '0;
                        r_werr    <= w_aw_err;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_wvalid) begin
                        r_widx <= r_widx + IDX_ONE;
                        r_wcnt <= r_wcnt + LEN_ONE;
                        if (r_wcnt == r_wlen) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_awready <= 1'b1;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_wstate  <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: load beat 0 on AR, then load the next beat on each accepted beat until last.
    always_ff @(posedge axiclk or posedge axi_rst) begin
        if (axi_rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rid     <= '0;
            r_rresp   <= RESP_OKAY;
            r_ridx    <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rerr    <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_arvalid) begin
                        r_rdata   <= w_ar_err ? '0 : w_ram_rdata;
                        r_rlast   <= (s_arlen == '0);
                        r_rid     <= s_arid;
                        r_rresp   <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
                        r_ridx    <= w_ar_idx + IDX_ONE;
                        r_rlen    <= s_arlen;
                        r_rcnt    <= '0;
                        r_rerr    <= w_ar_err;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rdata <= r_rerr ? '0 : w_ram_rdata;
                            r_ridx  <= r_ridx + IDX_ONE;
                            r_rcnt  <= r_rcnt + LEN_ONE;
                            r_rlast <= ((r_rcnt + LEN_ONE) == r_rlen);
                        end
                    end
                end
                default: begin
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                    r_arready <= 1'b1;
                    r_rstate  <= R_IDLE;
                end
            endcase
        end
    end

    assign s_awready   = r_awready;
    assign s_wready    = r_wready;
    assign s_bvalid    = r_bvalid;
    assign s_bid       = r_bid;
    assign s_bresp     = r_bresp;

    assign s_arready   = r_arready;
    assign s_rvalid    = r_rvalid;
    assign s_rlast     = r_rlast;
    assign s_rdata     = r_rdata;
    assign s_rid       = r_rid;
    assign s_rresp     = r_rresp;
    assign s_rdata_par = odd_parity(r_rdata);

endmodule

// File: tb/tb_pcie_axi_target_ram.sv
// Randomised bench for pcie_axi_target_ram with a word-array reference model
// and a queue-based scoreboard for the B and R channels.
module tb_pcie_axi_target_ram;

    localparam int DEPTH = 64;

    logic         axiclk;
    logic         axi_rst;
    logic [63:0]  s_awaddr;
    logic [7:0]   s_awid;
    logic [7:0]   s_awlen;
    logic [2:0]   s_awsize;
    logic         s_awvalid;
    logic         s_awready;
    logic [255:0] s_wdata;
    logic [31:0]  s_wstrb;
    logic         s_wvalid;
    logic         s_wready;
    logic [7:0]   s_bid;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready;
    logic [63:0]  s_araddr;
    logic [7:0]   s_arid;
    logic [7:0]   s_arlen;
    logic [2:0]   s_arsize;
    logic         s_arvalid;
    logic         s_arready;
    logic [255:0] s_rdata;
    logic [31:0]  s_rdata_par;
    logic [7:0]   s_rid;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic         s_rvalid;
    logic         s_rready;

    pcie_axi_target_ram #(
        .DEPTH_LOG2 (6),
        .WIN_BITS   (20)
    ) dut (
        .axiclk      (axiclk),
        .axi_rst     (axi_rst),
        .s_awaddr    (s_awaddr),
        .s_awid      (s_awid),
        .s_awlen     (s_awlen),
        .s_awsize    (s_awsize),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_bid       (s_bid),
        .s_bresp     (s_bresp),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .s_araddr    (s_araddr),
        .s_arid      (s_arid),
        .s_arlen     (s_arlen),
        .s_arsize    (s_arsize),
        .s_arvalid   (s_arvalid),
        .s_arready   (s_arready),
        .s_rdata     (s_rdata),
        .s_rdata_par (s_rdata_par),
        .s_rid       (s_rid),
        .s_rresp     (s_rresp),
        .s_rlast     (s_rlast),
        .s_rvalid    (s_rvalid),
        .s_rready    (s_rready)
    );

    // ---------------- clock ----------------
    initial begin
        axiclk = 1'b0;
        forever #5 axiclk = ~axiclk;
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    // R entry: {id, resp, last, data}; B entry: {id, resp}
    logic [266:0] r_q[$];
    logic [9:0]   b_q[$];
    logic [255:0] model_mem [DEPTH];

    int rready_pct   = 100;
    int bready_pct   = 100;
    int rready_block = 0;
    int wgap_max     = 0;

    // Reference rules: only 32-byte beats inside the first 2 KB of the 1 MB window are legal.
    function automatic bit model_err(input logic [63:0] a, input logic [2:0] sz);
        longint off;
        off = longint'(a % 64'd1048576);
        return (sz != 3'd5) || (off >= 2048);
    endfunction

    function automatic int model_idx(input logic [63:0] a, input int beat);
        longint off;
        off = longint'(a % 64'd1048576);
        return int'(((off / 32) + beat) % DEPTH);
    endfunction

    function automatic logic [31:0] model_par(input logic [255:0] d);
        logic [31:0] p;
        for (int k = 0; k < 32; k++) begin
            logic [7:0] by;
            by = d[8*k +: 8];
            p[k] = (($countones(by) % 2) == 0);
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [63:0] addr, input logic [7:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [31:0] strb, input bit rand_strb,
                            input bit ones, input int abort_at);
        bit           err;
        int           bound;
        logic [255:0] d;
        logic [31:0]  st;
        err = model_err(addr, size);
        if (abort_at < 0) b_q.push_back({id, err ? 2'b10 : 2'b00});
        @(negedge axiclk);
        s_awaddr  = addr;
        s_awid    = id;
        s_awlen   = len;
        s_awsize  = size;
        s_awvalid = 1'b1;
        bound = 0;
        while (!s_awready && bound < 1000) begin
            @(negedge axiclk);
            bound++;
        end
        if (!s_awready) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready=0 after %0d cycles, required 1", bound);
            s_awvalid = 1'b0;
            return;
        end
        @(posedge axiclk);
        @(negedge axiclk);
        s_awvalid = 1'b0;
        for (int beat = 0; beat <= int'(len); beat++) begin
            if (wgap_max > 0) begin
                s_wvalid = 1'b0;
                repeat ($urandom_range(0, wgap_max)) @(negedge axiclk);
            end
            for (int k = 0; k < 8; k++) d[32*k +: 32] = ones ? 32'hFFFF_FFFF : $urandom();
            st = rand_strb ? $urandom() : strb;
            s_wdata  = d;
            s_wstrb  = st;
            s_wvalid = 1'b1;
            if (beat == abort_at) begin
                axi_rst = 1'b1;
                #1;
                check("rst_bvalid", 64'(s_bvalid), 64'd0);
                check("rst_rvalid", 64'(s_rvalid), 64'd0);
                check("rst_rlast",  64'(s_rlast),  64'd0);
                check("rst_wready", 64'(s_wready), 64'd0);
                @(negedge axiclk);
                s_wvalid = 1'b0;
                @(negedge axiclk);
                axi_rst = 1'b0;
                return;
            end
            bound = 0;
            while (!s_wready && bound < 1000) begin
                @(negedge axiclk);
                bound++;
            end
            if (!s_wready) begin
                checks++; errors++;
                $display("FAIL w_timeout: wready=0 at beat %0d, required 1", beat);
                s_wvalid = 1'b0;
                return;
            end
            @(posedge axiclk);
            if (!err) begin
                for (int k = 0; k < 32; k++) begin
                    if (st[k]) model_mem[model_idx(addr, beat)][8*k +: 8] = d[8*k +: 8];
                end
            end
            @(negedge axiclk);
        end
        s_wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] id, input logic [7:0] len,
                           input logic [2:0] size);
        bit err;
        int bound;
        err = model_err(addr, size);
        for (int beat = 0; beat <= int'(len); beat++) begin
            r_q.push_back({id, err ? 2'b10 : 2'b00, beat == int'(len),
                           err ? 256'd0 : model_mem[model_idx(addr, beat)]});
        end
        @(negedge axiclk);
        s_araddr  = addr;
        s_arid    = id;
        s_arlen   = len;
        s_arsize  = size;
        s_arvalid = 1'b1;
        bound = 0;
        while (!s_arready && bound < 1000) begin
            @(negedge axiclk);
            bound++;
        end
        if (!s_arready) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arready=0 after %0d cycles, required 1", bound);
            s_arvalid = 1'b0;
            return;
        end
        @(posedge axiclk);
        @(negedge axiclk);
        s_arvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((r_q.size() != 0 || b_q.size() != 0) && n < 3000) begin
            @(negedge axiclk);
            n++;
        end
        checks++;
        if (r_q.size() != 0 || b_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d R beats and %0d B responses outstanding, required 0",
                     r_q.size(), b_q.size());
            r_q.delete();
            b_q.delete();
        end
    endtask

    // ---------------- monitor: ready generation, stability and scoreboard ----------------
    initial begin
        bit           hold_r;
        bit           hold_b;
        logic [298:0] held_r;
        logic [9:0]   held_b;
        logic [298:0] now_r;
        logic [9:0]   now_b;
        logic [266:0] e;
        hold_r   = 1'b0;
        hold_b   = 1'b0;
        held_r   = '0;
        held_b   = '0;
        s_rready = 1'b0;
        s_bready = 1'b0;
        forever begin
            @(negedge axiclk);
            if (axi_rst) begin
                hold_r = 1'b0;
                hold_b = 1'b0;
                continue;
            end
            now_r = {s_rid, s_rresp, s_rlast, s_rdata, s_rdata_par};
            now_b = {s_bid, s_bresp};
            if (hold_r) begin
                checks++;
                if (!s_rvalid || now_r !== held_r) begin
                    errors++;
                    $display("FAIL r_hold: rvalid=%b outputs=%h, required rvalid=1 outputs=%h",
                             s_rvalid, now_r, held_r);
                end
            end
            if (hold_b) begin
                checks++;
                if (!s_bvalid || now_b !== held_b) begin
                    errors++;
                    $display("FAIL b_hold: bvalid=%b id/resp=%h, required bvalid=1 id/resp=%h",
                             s_bvalid, now_b, held_b);
                end
            end
            if (rready_block > 0) begin
                s_rready = 1'b0;
                rready_block--;
            end else begin
                s_rready = ($urandom_range(0, 99) < rready_pct);
            end
            s_bready = ($urandom_range(0, 99) < bready_pct);
            if (s_rvalid && s_rready) begin
                checks++;
                if (r_q.size() == 0) begin
                    errors++;
                    $display("FAIL r_unexpected: beat id=%h with nothing outstanding", s_rid);
                end else begin
                    e = r_q.pop_front();
                    if ({s_rid, s_rresp, s_rlast, s_rdata} !== e) begin
                        errors++;
                        $display("FAIL r_beat: got id=%h resp=%h last=%b data=%h, required id=%h resp=%h last=%b data=%h",
                                 s_rid, s_rresp, s_rlast, s_rdata, e[266:259], e[258:257], e[256], e[255:0]);
                    end
                    checks++;
                    if (s_rdata_par !== model_par(e[255:0])) begin
                        errors++;
                        $display("FAIL r_parity: got %h required %h", s_rdata_par, model_par(e[255:0]));
                    end
                end
            end
            if (s_bvalid && s_bready) begin
                checks++;
                if (b_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected: response id=%h with nothing outstanding", s_bid);
                end else begin
                    logic [9:0] eb;
                    eb = b_q.pop_front();
                    if (now_b !== eb) begin
                        errors++;
                        $display("FAIL b_resp: got id=%h resp=%h, required id=%h resp=%h",
                                 s_bid, s_bresp, eb[9:2], eb[1:0]);
                    end
                end
            end
            hold_r = s_rvalid && !s_rready;
            hold_b = s_bvalid && !s_bready;
            held_r = now_r;
            held_b = now_b;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int bound;
        axi_rst   = 1'b1;
        s_awaddr  = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awvalid = 1'b0;
        s_wdata   = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_araddr  = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arvalid = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        repeat (3) @(negedge axiclk);
        check("reset_bvalid", 64'(s_bvalid), 64'd0);
        check("reset_rvalid", 64'(s_rvalid), 64'd0);
        check("reset_rlast",  64'(s_rlast),  64'd0);
        check("reset_bid",    64'(s_bid),    64'd0);
        check("reset_rid",    64'(s_rid),    64'd0);
        check("reset_bresp",  64'(s_bresp),  64'd0);
        check("reset_rresp",  64'(s_rresp),  64'd0);
        check("reset_rdata_nonzero", 64'(|s_rdata), 64'd0);
        axi_rst = 1'b0;
        @(negedge axiclk);
        check("idle_awready", 64'(s_awready), 64'd1);
        check("idle_arready", 64'(s_arready), 64'd1);
        check("idle_wready",  64'(s_wready),  64'd0);

        // Fill the whole array so every later read has a known reference.
        do_write(64'h0, 8'h01, 8'd63, 3'd5, '1, 1'b0, 1'b0, -1);
        wait_drain();

        // Basic 4-beat write and read-back with distinct IDs and B backpressure.
        bready_pct = 60;
        do_write(64'h40, 8'h5A, 8'd3, 3'd5, '1, 1'b0, 1'b0, -1);
        do_read (64'h40, 8'hA5, 8'd3, 3'd5);
        wait_drain();

        // Partial strobe over an all-ones word.
        do_write(64'd320, 8'h10, 8'd0, 3'd5, '1, 1'b0, 1'b1, -1);
        do_write(64'd320, 8'h11, 8'd0, 3'd5, 32'h0000_000F, 1'b0, 1'b0, -1);
        do_read (64'd320, 8'h12, 8'd0, 3'd5);
        wait_drain();

        // Burst wrapping from word 62 through 0 and 1.
        do_write(64'd1984, 8'h21, 8'd3, 3'd5, '1, 1'b0, 1'b0, -1);
        do_read (64'd1984, 8'h22, 8'd3, 3'd5);
        wait_drain();
        do_read (64'h0, 8'h23, 8'd1, 3'd5);
        wait_drain();

        // Illegal size and out-of-RAM window offset, on both channels.
        do_read (64'h40, 8'h31, 8'd2, 3'd4);
        wait_drain();
        do_read (64'h800, 8'h32, 8'd1, 3'd5);
        wait_drain();
        do_write(64'h20, 8'h33, 8'd1, 3'd4, '1, 1'b0, 1'b0, -1);
        do_write(64'h800, 8'h34, 8'd1, 3'd5, '1, 1'b0, 1'b0, -1);
        do_read (64'h0, 8'h35, 8'd2, 3'd5);
        wait_drain();

        // Bits above the window are ignored.
        do_write(64'hFFFF_FFFF_FFF0_0060, 8'h41, 8'd0, 3'd5, '1, 1'b0, 1'b0, -1);
        do_read (64'h0000_0000_0000_0060, 8'h42, 8'd0, 3'd5);
        wait_drain();

        // Long R stall in the middle of a burst.
        rready_pct = 100;
        do_read(64'h100, 8'h51, 8'd7, 3'd5);
        bound = 0;
        while (!s_rvalid && bound < 100) begin
            @(negedge axiclk);
            bound++;
        end
        check("stall_rvalid_seen", 64'(s_rvalid), 64'd1);
        rready_block = 5;
        wait_drain();

        // Concurrent write and read on disjoint words.
        rready_pct = 70;
        fork
            do_write(64'd640,  8'h61, 8'd3, 3'd5, '0, 1'b1, 1'b0, -1);
            do_read (64'd1280, 8'h62, 8'd3, 3'd5);
        join
        wait_drain();

        // Random traffic with backpressure and W gaps.
        wgap_max = 2;
        for (int it = 0; it < 40; it++) begin
            logic [63:0] a;
            logic [2:0]  sz;
            logic [7:0]  ln;
            rready_pct = $urandom_range(30, 100);
            bready_pct = $urandom_range(30, 100);
            a  = {32'($urandom()), 12'($urandom_range(0, 4095)),
                  20'($urandom_range(0, 63) * 32 + $urandom_range(0, 31))};
            sz = 3'd5;
            ln = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) a = a | (64'd1 << $urandom_range(11, 19));
            if ($urandom_range(0, 7) == 0) sz = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, 8'($urandom()), ln, sz, '0, 1'b1, 1'b0, -1);
            end else begin
                do_read(a, 8'($urandom()), ln, sz);
                wait_drain();
            end
        end
        wgap_max = 0;
        wait_drain();

        // Reset during beat 2 of a 4-beat write, then recover.
        bready_pct = 100;
        rready_pct = 100;
        do_write(64'h200, 8'h77, 8'd3, 3'd5, '1, 1'b0, 1'b0, 1);
        repeat (3) @(negedge axiclk);
        check("post_rst_bvalid", 64'(s_bvalid), 64'd0);
        check("post_rst_awready", 64'(s_awready), 64'd1);
        do_write(64'h300, 8'h78, 8'd3, 3'd5, '1, 1'b0, 1'b0, -1);
        do_read (64'h300, 8'h79, 8'd3, 3'd5);
        wait_drain();
        do_read (64'h200, 8'h7A, 8'd3, 3'd5);
        wait_drain();

        repeat (5) @(negedge axiclk);
        check("final_r_q_empty", 64'(r_q.size()), 64'd0);
        check("final_b_q_empty", 64'(b_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
